store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write data-memory port for the pipelined MIPS core; sits directly downstream of the core's memory stage.
- Consumes the memory-stage store stream (memwriteM, aluoutM, writedataM) and returns readdataM for loads.
- Stores are queued in a FIFO and drained to a slower backing memory over a req/ack write handshake, so a store never waits on the bus in the core's memory stage.
- Loads read the backing memory combinationally, with store-to-load forwarding from the queue.

Parameters:
- DEPTH, 4, number of queued stores; power of two, ≥2.
- AW, 32, address width; word granularity uses AW-1:2.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset (reset=0 clears state on next rising clk edge)
- memwriteM  in  1  store request from memory stage
- aluoutM  in  AW  load/store byte address; bits 1:0 ignored
- writedataM  in  32  store data
- readdataM  out  32  load data (combinational)
- bus_wreq  out  1  write request to backing memory
- bus_waddr  out  AW  write address, head entry, bits 1:0 forced 0
- bus_wdata  out  32  write data, head entry
- bus_wack  in  1  backing memory accepted head write this cycle
- bus_raddr  out  AW  read address = aluoutM with bits 1:0 forced 0
- bus_rdata  in  32  backing-memory read data (combinational in bus_raddr)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: a store was dropped

Behaviour:
- State: circular FIFO of DEPTH {addr word, data} entries; head ptr, tail ptr, count (log2(DEPTH)+1 bits); overflow flag.
- Reset (reset=0 at clk edge):
  - ptrs=0, count=0, overflow=0.
  - Outputs next cycle: bus_wreq=0, empty=1, full=0, overflow=0.
  - Queued entries discarded.
  - Reset overrides bus_wack and memwriteM in the same cycle.
- Dequeue (deq) = bus_wreq & bus_wack.
  - Head advances (mod DEPTH) and count decrements.
  - The next entry, if any, is presented the following cycle.
- Write handshake:
  - bus_wreq = !empty.
  - bus_waddr/bus_wdata reflect the head entry and stay stable while bus_wreq=1 and bus_wack=0.
  - Back-to-back acks drain one entry per cycle.
  - bus_wack while bus_wreq=0 is ignored.
- Enqueue (enq) = memwriteM & (!full | deq).
  - Writes {aluoutM[AW-1:2], writedataM} at tail; tail advances mod DEPTH.
- Count update:
  - +1 if enq & !deq.
  - −1 if deq & !enq.
  - Unchanged if both or neither.
- Full with simultaneous deq: the store is accepted, count stays DEPTH.
- Empty with simultaneous memwriteM: the store is enqueued.
  - It cannot be dequeued the same cycle, because bus_wreq was 0.
  - bus_wreq rises the next cycle.
- Overflow: memwriteM & full & !deq → store dropped, state unchanged, overflow←1 until reset.
- Latency: a store accepted at edge N is visible on bus_wreq/bus_waddr/bus_wdata after edge N when the queue was empty; otherwise after the entries ahead of it drain.
- Load path (combinational):
  - bus_raddr = {aluoutM[AW-1:2],2'b00}.
  - readdataM = data of the youngest valid queue entry whose addr word equals aluoutM[AW-1:2]; else bus_rdata.
  - Youngest is determined by age from tail backward, wrap-aware.
  - Forwarding is from registered entries only. An entry dequeued in the current cycle is still valid this cycle.
  - readdataM is defined every cycle regardless of memwriteM.
- Pointer wrap: ptrs are log2(DEPTH) bits and wrap naturally; full/empty are derived from count, never from pointer equality alone.
- No byte/halfword stores; word only. Byte extraction for lb stays in the core.

Test Plan:
- Reset then idle:
  - Drive reset=0 for 2 cycles, memwriteM=1 during reset.
  - Required after release: empty=1, bus_wreq=0, overflow=0, no entry queued.
- Single store, delayed ack:
  - Store addr 0x100, data 0xDEADBEEF.
  - bus_wreq=1 next cycle, bus_waddr=0x100, bus_wdata=0xDEADBEEF.
  - Hold bus_wack=0 for 3 cycles: outputs stable.
  - Ack 1 cycle: empty=1, bus_wreq=0 next cycle.
- Forwarding:
  - Store 0x40←0x11111111, then 0x40←0x22222222, bus_wack=0, bus_rdata=0xAAAAAAAA.
  - Load aluoutM=0x42 → readdataM=0x22222222.
  - Load 0x44 → readdataM=0xAAAAAAAA.
- Fill and overflow (DEPTH=4, bus_wack=0):
  - 4 stores → full=1.
  - 5th store (0x50←0x55) dropped, overflow=1, count stays 4.
  - Drain shows the original 4 addresses in order; overflow stays 1.
- Full with simultaneous enq+deq:
  - Full queue, bus_wack=1 and memwriteM=1 (0x60←0x66) same cycle.
  - full stays 1, overflow=0.
  - Head advances; the 0x60 entry drains last, after 4 more acks.
- Wrap and reset mid-operation:
  - Stream 10 stores with ack every other cycle; order is preserved across pointer wrap.
  - Assert reset=0 while bus_wreq=1 and bus_wack=1: queue empty next cycle, no further bus_wreq.

Source files
------------

// File: rtl/store_buffer_if.sv
// Memory-stage store/load signals and backing-memory bus for the posted-write store buffer.
// The slave modport belongs to the store buffer. The master modport belongs to the core/memory side.
interface store_buffer_if #(
    parameter int AW = 32
);
    logic          memwriteM;
    logic [AW-1:0] aluoutM;
    logic [31:0]   writedataM;
    logic [31:0]   readdataM;
    logic          bus_wreq;
    logic [AW-1:0] bus_waddr;
    logic [31:0]   bus_wdata;
    logic          bus_wack;
    logic [AW-1:0] bus_raddr;
    logic [31:0]   bus_rdata;
    logic          full;
    logic          empty;
    logic          overflow;

    modport slave (
        input  memwriteM, aluoutM, writedataM, bus_wack, bus_rdata,
        output readdataM, bus_wreq, bus_waddr, bus_wdata, bus_raddr, full, empty, overflow
    );

    modport master (
        output memwriteM, aluoutM, writedataM, bus_wack, bus_rdata,
        input  readdataM, bus_wreq, bus_waddr, bus_wdata, bus_raddr, full, empty, overflow
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store queue between the MIPS memory stage and a slower backing memory.
// Loads read the backing memory and forward from the youngest queued store to the same word.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-3:0] addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          ovf;

    logic          full;
    logic          empty;
    logic          deq;
    logic          enq;
    logic [PW-1:0] idx;
    logic [31:0]   rd;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign deq   = !empty && sb.bus_wack;
    // A full queue still takes a store when the head leaves in the same cycle.
    assign enq   = sb.memwriteM && (!full || deq);

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (deq) head <= head + PW'(1);
            if (enq) tail <= tail + PW'(1);
            if (enq && !deq) begin
                count <= count + CW'(1);
            end else if (deq && !enq) begin
                count <= count - CW'(1);
            end
            if (sb.memwriteM && full && !deq) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && enq) begin
            addr_q[tail] <= sb.aluoutM[AW-1:2];
            data_q[tail] <= sb.writedataM;
        end
    end

    // Walk from the oldest to the youngest entry so the youngest match wins.
    always_comb begin
        rd  = sb.bus_rdata;
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            idx = tail - PW'(i + 1);
            if ((CW'(i) < count) && (addr_q[idx] == sb.aluoutM[AW-1:2])) begin
                rd = data_q[idx];
            end
        end
    end

    assign sb.readdataM = rd;
    assign sb.bus_raddr = {sb.aluoutM[AW-1:2], 2'b00};
    assign sb.bus_wreq  = !empty;
    assign sb.bus_waddr = {addr_q[head], 2'b00};
    assign sb.bus_wdata = data_q[head];
    assign sb.full      = full;
    assign sb.empty     = empty;
    assign sb.overflow  = ovf;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a queue of expected stores is pushed on accept and popped on ack.
module tb_store_buffer;
    logic clk = 1'b0;
    logic reset;

    store_buffer_if #(.AW(32)) sb();

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t exp_q[$];
    logic   m_ovf;
    logic   chk_en;
    int     checks;
    int     failures;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a);
        logic [31:0] v;
        v = sb.bus_rdata;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].addr == a[31:2]) begin
                v = exp_q[i].data;
                break;
            end
        end
        return v;
    endfunction

    // Compare at the negedge, then advance the model with the inputs sampled at the posedge.
    task automatic cycle();
        entry_t e;
        bit     d;
        bit     f;
        bit     en;
        @(negedge clk);
        if (chk_en) begin
            check("empty",    64'(sb.empty),    64'(exp_q.size() == 0));
            check("full",     64'(sb.full),     64'(exp_q.size() == 4));
            check("bus_wreq", 64'(sb.bus_wreq), 64'(exp_q.size() != 0));
            check("overflow", 64'(sb.overflow), 64'(m_ovf));
            check("bus_raddr", 64'(sb.bus_raddr), 64'({sb.aluoutM[31:2], 2'b00}));
            check("readdataM", 64'(sb.readdataM), 64'(model_load(sb.aluoutM)));
            if (exp_q.size() != 0) begin
                check("bus_waddr", 64'(sb.bus_waddr), 64'({exp_q[0].addr, 2'b00}));
                check("bus_wdata", 64'(sb.bus_wdata), 64'(exp_q[0].data));
            end
        end
        @(posedge clk);
        if (!reset) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            d  = (exp_q.size() != 0) && sb.bus_wack;
            f  = (exp_q.size() == 4);
            en = sb.memwriteM && (!f || d);
            if (d) void'(exp_q.pop_front());
            if (en) begin
                e.addr = sb.aluoutM[31:2];
                e.data = sb.writedataM;
                exp_q.push_back(e);
            end
            if (sb.memwriteM && f && !d) m_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic ack);
        sb.memwriteM  = 1'b1;
        sb.aluoutM    = a;
        sb.writedataM = d;
        sb.bus_wack   = ack;
        cycle();
        sb.memwriteM  = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        chk_en = 1'b0;
        m_ovf = 1'b0;
        sb.bus_rdata  = 32'h1234_5678;
        sb.bus_wack   = 1'b0;

        // Reset with a store pending: the store must not be queued.
        reset = 1'b0;
        sb.memwriteM  = 1'b1;
        sb.aluoutM    = 32'h200;
        sb.writedataM = 32'h1;
        cycle();
        chk_en = 1'b1;
        cycle();
        reset = 1'b1;
        sb.memwriteM = 1'b0;
        cycle();
        cycle();

        // Single store held off by the bus for three cycles, then acked.
        store(32'h100, 32'hDEAD_BEEF, 1'b0);
        check("single_wreq_held", 64'(sb.bus_wreq), 64'd1);
        for (int i = 0; i < 3; i++) cycle();
        sb.bus_wack = 1'b1;
        cycle();
        sb.bus_wack = 1'b0;
        check("single_drained", 64'(sb.empty), 64'd1);
        cycle();

        // Forwarding from the younger of two stores to the same word.
        sb.bus_rdata = 32'hAAAA_AAAA;
        store(32'h40, 32'h1111_1111, 1'b0);
        store(32'h40, 32'h2222_2222, 1'b0);
        sb.aluoutM = 32'h42;
        #1 check("fwd_young", 64'(sb.readdataM), 64'h2222_2222);
        cycle();
        sb.aluoutM = 32'h44;
        #1 check("fwd_miss", 64'(sb.readdataM), 64'hAAAA_AAAA);
        cycle();
        sb.bus_wack = 1'b1;
        sb.aluoutM  = 32'h40;
        cycle();
        cycle();
        sb.bus_wack = 1'b0;
        cycle();

        // Fill, overflow, then drain in order.
        for (int i = 0; i < 4; i++) store(32'h10 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0);
        check("fill_full", 64'(sb.full), 64'd1);
        store(32'h50, 32'h55, 1'b0);
        check("ovf_set", 64'(sb.overflow), 64'd1);
        sb.bus_wack = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        sb.bus_wack = 1'b0;
        cycle();
        check("ovf_sticky", 64'(sb.overflow), 64'd1);

        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();

        // Full with simultaneous enqueue and dequeue.
        for (int i = 0; i < 4; i++) store(32'h20 + 32'(4 * i), 32'hD0 + 32'(i), 1'b0);
        store(32'h60, 32'h66, 1'b1);
        check("full_enq_deq_full", 64'(sb.full), 64'd1);
        check("full_enq_deq_ovf", 64'(sb.overflow), 64'd0);
        sb.bus_wack = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("last_is_0x60", 64'(sb.bus_waddr), 64'h60);
        cycle();
        sb.bus_wack = 1'b0;
        cycle();

        // Stream across pointer wrap with ack every other cycle.
        for (int i = 0; i < 10; i++) store(32'h300 + 32'(4 * i), 32'hE000 + 32'(i), 1'(i % 2));
        sb.bus_wack = 1'b1;
        cycle();
        check("mid_wreq", 64'(sb.bus_wreq), 64'd1);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("post_reset_empty", 64'(sb.empty), 64'd1);
        check("post_reset_wreq", 64'(sb.bus_wreq), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
